// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
//   UART RX frame-tail checker. It checks the optional parity bit and the one or
//   two stop bits that follow the data bits already captured by the deserialiser.
//   For each frame it reports parity/stop errors and a frame-done strobe, and it
//   keeps a saturating count of bad frames.
//
//   Optional build macro: BREAK_DET_EN
//     defined   : brk_det pulses with frame_done on an all-zero (break) frame, and
//                 break frames are not counted in err_cnt.
//     undefined : brk_det is tied to 0, and break frames count as stop errors.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop_bits,
  input  logic                  chk_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  err_clr,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  brk_det
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PAR   = 3'd1;
  localparam logic [2:0] ST_STOP1 = 3'd2;
  localparam logic [2:0] ST_STOP2 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 exp_par;
  logic                 par_err_q;
  logic                 stp_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 in_tail;
  logic                 bit_take;
  logic                 done_pulse;
  logic                 frame_bad;
  logic                 brk_frame;
  logic                 cnt_inc;

  // A tail bit is taken only in a bit-waiting state and only when it does not
  // collide with a new chk_start. A new start always takes priority.
  assign in_tail  = (state == ST_PAR) || (state == ST_STOP1) || (state == ST_STOP2);
  assign bit_take = bit_valid && !chk_start && in_tail;

  // If a chk_start arrives in the DONE cycle, the old frame is dropped. It gets
  // no done strobe and is not counted.
  assign done_pulse = (state == ST_DONE) && !chk_start;
  assign frame_bad  = par_err_q || stp_err_q;

  // Next state: a chk_start restarts from any state; otherwise step on each accepted bit.
  always_comb begin
    state_nxt = state;
    if (chk_start) begin
      state_nxt = par_en ? ST_PAR : ST_STOP1;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_PAR:   if (bit_valid) state_nxt = ST_STOP1;
        ST_STOP1: if (bit_valid) state_nxt = stop_bits ? ST_STOP2 : ST_DONE;
        ST_STOP2: if (bit_valid) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register; an asynchronous reset returns to IDLE even in the middle of a frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the expected parity at start, then update the error flags as the tail bits arrive.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_par   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else if (chk_start) begin
      exp_par   <= (^data_in) ^ par_typ;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else if (bit_take) begin
      case (state)
        ST_PAR:             par_err_q <= (sampled_bit != exp_par);
        ST_STOP1, ST_STOP2: stp_err_q <= stp_err_q | ~sampled_bit;
        default:            ;
      endcase
    end
  end

`ifdef BREAK_DET_EN
  logic brk_cand;

  // A break candidate starts as an all-zero data word and is dropped on any tail bit that is 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      brk_cand <= 1'b0;
    end else if (chk_start) begin
      brk_cand <= (data_in == '0);
    end else if (bit_take && sampled_bit) begin
      brk_cand <= 1'b0;
    end
  end

  assign brk_frame = brk_cand;
  assign brk_det   = done_pulse && brk_cand;
`else
  assign brk_frame = 1'b0;
  assign brk_det   = 1'b0;
`endif

  assign cnt_inc = done_pulse && frame_bad && !brk_frame && (err_cnt_q != CNT_MAX);

  // Saturating bad-frame counter. A clear wins over an increment in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (cnt_inc) begin
      err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign frame_done = done_pulse;
  assign frame_ok   = done_pulse && !frame_bad;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb_uart_rx_frame_checker
//   Scoreboard bench. The stimulus side computes each frame's expected result
//   from the UART framing rules and queues it. A monitor pops and compares the
//   queued result whenever the checker strobes frame_done.
module tb_uart_rx_frame_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       par_en = 1'b0, par_typ = 1'b0, stop_bits = 1'b0;
  logic       chk_start = 1'b0, bit_valid = 1'b0, sampled_bit = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       par_err, stp_err, frame_done, frame_ok, brk_det;
  logic [7:0] err_cnt;

  typedef struct packed {
    logic       par;
    logic       stp;
    logic       ok;
    logic       brk;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;
  logic cnt_pend = 1'b0;
  logic [7:0] cnt_exp = 8'h00;

  uart_rx_frame_checker #(.DATA_WIDTH(8), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_typ(par_typ), .stop_bits(stop_bits),
    .chk_start(chk_start), .data_in(data_in), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .err_clr(err_clr), .par_err(par_err), .stp_err(stp_err),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_cnt(err_cnt), .brk_det(brk_det)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one frame. abort_after >= 0 stops after that many tail bits, so the
  // next chk_start abandons the frame.
  task automatic applyStimulus(input logic [7:0] d, input bit pe, input bit pt, input bit sb,
                               input bit pbit, input bit s1, input bit s2,
                               input bit clr_done, input int abort_after);
    bit bits[3];
    int nbits;
    int ones;
    bit exp_par, exp_stp, exp_brk;
    exp_t e;
    nbits = 0;
    if (pe) begin bits[nbits] = pbit; nbits++; end
    bits[nbits] = s1; nbits++;
    if (sb) begin bits[nbits] = s2; nbits++; end

    if (abort_after < 0) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      // Even parity wants an even total of ones; odd parity wants an odd total.
      exp_par = pe && (((ones + int'(pbit)) % 2) != int'(pt));
      exp_stp = !s1 || (sb && !s2);
      exp_brk = 1'b0;
`ifdef BREAK_DET_EN
      exp_brk = (d == 8'h00) && (!pe || !pbit) && !s1 && (!sb || !s2);
`endif
      if (clr_done) model_cnt = 0;
      else if ((exp_par || exp_stp) && !exp_brk && model_cnt < 255) model_cnt++;
      e.par = exp_par;
      e.stp = exp_stp;
      e.ok  = !(exp_par || exp_stp);
      e.brk = exp_brk;
      e.cnt = 8'(model_cnt);
      exp_q.push_back(e);
    end

    @(posedge CLK); #1;
    par_en = pe; par_typ = pt; stop_bits = sb;
    data_in = d; chk_start = 1'b1;
    bit_valid = 1'($urandom % 2); sampled_bit = 1'($urandom % 2);
    @(posedge CLK); #1;
    chk_start = 1'b0; bit_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_after) return;
      repeat ($urandom % 3) begin
        sampled_bit = 1'($urandom % 2);
        @(posedge CLK); #1;
      end
      bit_valid = 1'b1; sampled_bit = bits[i];
      @(posedge CLK); #1;
      bit_valid = 1'b0;
    end
    err_clr = clr_done;
    bit_valid = 1'($urandom % 2);
    @(posedge CLK); #1;
    err_clr = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic clearCount();
    @(posedge CLK); #1;
    err_clr = 1'b1;
    @(posedge CLK); #1;
    err_clr = 1'b0;
    model_cnt = 0;
  endtask

  // Monitor: compare each frame_done against the oldest queued expectation,
  // then check err_cnt on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (cnt_pend) begin
        checkOutput("err_cnt", 32'(err_cnt), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (RST && frame_done) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_frame_done: got 1, expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("par_err", 32'(par_err), 32'(e.par));
          checkOutput("stp_err", 32'(stp_err), 32'(e.stp));
          checkOutput("frame_ok", 32'(frame_ok), 32'(e.ok));
          checkOutput("brk_det", 32'(brk_det), 32'(e.brk));
          cnt_pend = 1'b1;
          cnt_exp  = e.cnt;
        end
      end
    end
  end

  initial begin
    bit pe, pt, sb, pbit, s1, s2, clr;
    int ab, nb;
    logic [7:0] d;
    int waitc;

    #3;
    checkOutput("rst_par_err", 32'(par_err), 0);
    checkOutput("rst_stp_err", 32'(stp_err), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_frame_ok", 32'(frame_ok), 0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("rst_brk_det", 32'(brk_det), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    $display("[TB] reset released");

    applyStimulus(8'hA5, 0, 0, 0, 0, 1, 1, 0, -1);
    applyStimulus(8'h07, 1, 0, 0, 0, 1, 1, 0, -1);
    applyStimulus(8'h3C, 0, 0, 1, 0, 1, 0, 0, -1);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i), 0, 0, 0, 0, 0, 0, 0, -1);

    // A reset in the middle of a frame clears everything, including a saturated count.
    applyStimulus(8'h55, 1, 1, 0, 1, 1, 1, 0, 1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midrst_err_cnt", 32'(err_cnt), 0);
    checkOutput("midrst_stp_err", 32'(stp_err), 0);
    checkOutput("midrst_frame_done", 32'(frame_done), 0);
    model_cnt = 0;
    @(posedge CLK); #1;
    RST = 1'b1;

    applyStimulus(8'h11, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(8'h22, 0, 0, 0, 0, 1, 1, 0, -1);
    applyStimulus(8'h01, 1, 1, 0, 0, 1, 1, 0, -1);
    applyStimulus(8'h02, 0, 0, 0, 0, 0, 1, 1, -1);
    applyStimulus(8'h00, 1, 0, 0, 0, 0, 0, 0, -1);
    applyStimulus(8'h00, 1, 1, 1, 0, 0, 0, 0, -1);

    for (int i = 0; i < 200; i++) begin
      pe = 1'($urandom % 2); pt = 1'($urandom % 2); sb = 1'($urandom % 2);
      d  = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
      pbit = 1'($urandom % 2);
      s1 = ($urandom % 10) >= 3; s2 = ($urandom % 10) >= 3;
      if ($urandom % 5 == 0) begin s1 = 1'b0; s2 = 1'b0; pbit = 1'b0; end
      clr = ($urandom % 10) == 0;
      nb = int'(pe) + 1 + int'(sb);
      ab = (($urandom % 10) == 0) ? int'($urandom % nb) : -1;
      applyStimulus(d, pe, pt, sb, pbit, s1, s2, clr, ab);
      if ($urandom % 20 == 0) clearCount();
    end

    waitc = 0;
    while ((exp_q.size() != 0 || cnt_pend) && waitc < 20) begin
      @(posedge CLK);
      waitc++;
    end
    repeat (2) @(posedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_frame_done: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
